pipe_hazard_ctrl: RTL

- Parametrised hazard and forwarding controller for the 5-stage pipelined CPU.
- Keeps its own scoreboard of in-flight destination registers, one slot per stage from EX to WB.
- Drives per-operand forwarding selects, load-use stall/bubble, and branch-taken flush.
- Counts stall and flush cycles for performance monitoring.
- Sits beside the IF/ID and ID/EX stage registers; DEPTH and load latency are generalised beyond the fixed 3-stage tail.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 20 ++
 rtl/pipe_hazard_ctrl_if.sv | 45 ++++
 rtl/pipe_hazard_ctrl_sb_shift_chain.sv | 31 +++
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
// Scoreboard slots carry a fixed-width rd field wide enough for any REG_AW <= RD_W.
package pipe_pkg;

    localparam int RD_W        = 8;
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic            is_load;
    } sb_slot_t;

    localparam sb_slot_t SB_BUBBLE = '{valid: 1'b0, rd: {RD_W{1'b0}}, is_load: 1'b0};

    function automatic int fwd_sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle between the ID stage and the hazard controller.
// master = pipeline front end, slave = hazard controller.
interface pipe_hazard_ctrl_if
    import pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 32
);
    localparam int SEL_W = fwd_sel_w(DEPTH);

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_is_load;
    logic              br_taken;

    logic              stall_f;
    logic              bubble_e;
    logic              flush_fd;
    logic              flush_de;
    logic [SEL_W-1:0]  fwd_rs_sel;
    logic [SEL_W-1:0]  fwd_rt_sel;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_rd, id_reg_write, id_is_load, br_taken,
        input  stall_f, bubble_e, flush_fd, flush_de,
               fwd_rs_sel, fwd_rt_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_rd, id_reg_write, id_is_load, br_taken,
        output stall_f, bubble_e, flush_fd, flush_de,
               fwd_rs_sel, fwd_rt_sel, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sb_shift_chain.sv
// In-flight destination scoreboard: slot 1 = EX ... slot DEPTH = WB.
// Each edge everything ages one slot; slot 1 takes the new entry or a bubble.
module sb_shift_chain
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  sb_slot_t            ins_slot,
    input  logic                ins_bubble,
    output sb_slot_t [DEPTH:1]  slots
);

    sb_slot_t [DEPTH:1] slot_r;

    // Age all slots by one stage; the oldest entry falls off the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r <= {DEPTH{SB_BUBBLE}};
        end else begin
            slot_r[1] <= ins_bubble ? SB_BUBBLE : ins_slot;
            for (int k = 2; k <= DEPTH; k++) begin
                slot_r[k] <= slot_r[k-1];
            end
        end
    end

    assign slots = slot_r;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller: operand lookup against the scoreboard,
// load-use stall, branch flush (flush wins), and saturating perf counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input logic               CLOCK,
    input logic               RESET,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int SEL_W = fwd_sel_w(DEPTH);

    sb_slot_t [DEPTH:1] slots_s;
    sb_slot_t           ins_slot_s;
    logic               ins_bubble_s;

    logic [RD_W-1:0]    rs_ext_s;
    logic [RD_W-1:0]    rt_ext_s;
    logic               rs_m_s;
    logic               rt_m_s;
    logic [SEL_W-1:0]   rs_k_s;
    logic [SEL_W-1:0]   rt_k_s;
    logic               rs_lh_s;
    logic               rt_lh_s;

    logic               flush_s;
    logic               stall_s;

    logic               stall_f_s;
    logic               bubble_e_s;
    logic               flush_fd_s;
    logic               flush_de_s;
    logic [SEL_W-1:0]   fwd_rs_s;
    logic [SEL_W-1:0]   fwd_rt_s;

    logic [CNT_W-1:0]   stall_cnt_r;
    logic [CNT_W-1:0]   flush_cnt_r;

    assign rs_ext_s = RD_W'(bus.id_rs);
    assign rt_ext_s = RD_W'(bus.id_rt);

    sb_shift_chain #(
        .DEPTH (DEPTH)
    ) u_sb (
        .clk        (CLOCK),
        .rst_n      (RESET),
        .ins_slot   (ins_slot_s),
        .ins_bubble (ins_bubble_s),
        .slots      (slots_s)
    );

    // Youngest matching slot wins: scan oldest to youngest so later hits override.
    // rd==0 can never match because such entries are never marked valid.
    always_comb begin
        rs_m_s  = 1'b0;
        rt_m_s  = 1'b0;
        rs_k_s  = SEL_W'(FWD_REGFILE);
        rt_k_s  = SEL_W'(FWD_REGFILE);
        rs_lh_s = 1'b0;
        rt_lh_s = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            rs_m_s  = bus.id_use_rs && slots_s[k].valid && (slots_s[k].rd == rs_ext_s);
            rt_m_s  = bus.id_use_rt && slots_s[k].valid && (slots_s[k].rd == rt_ext_s);
            rs_k_s  = rs_m_s ? SEL_W'(k) : rs_k_s;
            rt_k_s  = rt_m_s ? SEL_W'(k) : rt_k_s;
            rs_lh_s = rs_m_s ? (slots_s[k].is_load && (k <= LOAD_LAT)) : rs_lh_s;
            rt_lh_s = rt_m_s ? (slots_s[k].is_load && (k <= LOAD_LAT)) : rt_lh_s;
        end
    end

    // Stall/flush decision and the entry offered to scoreboard slot 1.
    always_comb begin
        flush_s            = bus.br_taken;
        stall_s            = bus.id_valid & (rs_lh_s | rt_lh_s) & ~flush_s;
        ins_bubble_s       = ~bus.id_valid | stall_s | flush_s;
        ins_slot_s.valid   = bus.id_reg_write & (bus.id_rd != {REG_AW{1'b0}});
        ins_slot_s.rd      = RD_W'(bus.id_rd);
        ins_slot_s.is_load = bus.id_is_load;
    end

    // Control outputs are combinational but held at zero while reset is asserted.
    always_comb begin
        if (!RESET) begin
            stall_f_s  = 1'b0;
            bubble_e_s = 1'b0;
            flush_fd_s = 1'b0;
            flush_de_s = 1'b0;
            fwd_rs_s   = SEL_W'(FWD_REGFILE);
            fwd_rt_s   = SEL_W'(FWD_REGFILE);
        end else begin
            stall_f_s  = stall_s;
            bubble_e_s = stall_s;
            flush_fd_s = flush_s;
            flush_de_s = flush_s;
            fwd_rs_s   = stall_s ? SEL_W'(FWD_REGFILE) : rs_k_s;
            fwd_rt_s   = stall_s ? SEL_W'(FWD_REGFILE) : rt_k_s;
        end
    end

    // Stall-cycle counter, sticks at all-ones.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_f_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Flush-cycle counter, sticks at all-ones.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (flush_fd_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1);
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    assign bus.stall_f    = stall_f_s;
    assign bus.bubble_e   = bubble_e_s;
    assign bus.flush_fd   = flush_fd_s;
    assign bus.flush_de   = flush_de_s;
    assign bus.fwd_rs_sel = fwd_rs_s;
    assign bus.fwd_rt_sel = fwd_rt_s;
    assign bus.stall_cnt  = stall_cnt_r;
    assign bus.flush_cnt  = flush_cnt_r;

endmodule
